// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared widths, FSM state encodings and opcodes for mem_responder
package mem_responder_pkg;

  localparam int WORD_SIZE = 16;
  localparam int STATE_W   = 2;
  localparam int CNT_W     = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_fsm.sv
// rtl/mem_port_fsm.sv - one memory port: IDLE/BUSY/DONE sequencing, latency counter, request latches
module mem_port_fsm
  import mem_responder_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 8,
  parameter int LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              req,
  input  logic              wr_req,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              rd_done,
  output logic              wr_commit,
  output logic [IDX_W-1:0]  idx_q,
  output logic [DATA_W-1:0] data_q
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op;
  logic             accept;
  logic             finish;

  // The edge leaving DONE doubles as the IDLE accept edge, so a held
  // request completes every LATENCY+1 cycles.
  assign accept = req && (state == ST_IDLE || state == ST_DONE);
  assign finish = (state == ST_BUSY) && (cnt == '0);

  assign ready     = (state == ST_DONE);
  assign rd_done   = ready && (op == OP_READ);
  assign wr_commit = ready && (op == OP_WRITE);

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op     <= OP_READ;
      idx_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      state <= ST_BUSY;
      cnt   <= CNT_LOAD;
      op    <= wr_req ? OP_WRITE : OP_READ;
      idx_q <= idx;
      if (wr_req) begin
        data_q <= wdata;
      end
    end else if (finish) begin
      state <= ST_DONE;
      // Read data is captured on entry to DONE, before any same-edge write commits.
      if (op == OP_READ) begin
        data_q <= rdata;
      end
    end else if (state == ST_BUSY) begin
      cnt <= cnt - 1'b1;
    end else begin
      state <= ST_IDLE;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - two-port memory responder: instruction read port and data read/write port
module mem_responder #(
  parameter int WORD_SIZE = mem_responder_pkg::WORD_SIZE,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 readM1,
  input  logic [WORD_SIZE-1:0] address1,
  output logic [WORD_SIZE-1:0] data1,
  output logic                 ready1,
  input  logic                 readM2,
  input  logic                 writeM2,
  input  logic [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2,
  output logic                 ready2
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic [IDX_W-1:0]     idx1_q;
  logic [IDX_W-1:0]     idx2_q;
  logic [WORD_SIZE-1:0] rdata1;
  logic [WORD_SIZE-1:0] rdata2;
  logic [WORD_SIZE-1:0] data_q2;
  logic                 rd_done1;
  logic                 wr_commit1;
  logic                 rd_done2;
  logic                 wr_commit2;
  logic                 unused_bits;

  assign rdata1 = mem[idx1_q];
  assign rdata2 = mem[idx2_q];

  mem_port_fsm #(
    .DATA_W  (WORD_SIZE),
    .IDX_W   (IDX_W),
    .LATENCY (LATENCY)
  ) u_port1 (
    .Clk       (Clk),
    .Reset_N   (Reset_N),
    .req       (readM1),
    .wr_req    (1'b0),
    .idx       (address1[IDX_W-1:0]),
    .wdata     ({WORD_SIZE{1'b0}}),
    .rdata     (rdata1),
    .ready     (ready1),
    .rd_done   (rd_done1),
    .wr_commit (wr_commit1),
    .idx_q     (idx1_q),
    .data_q    (data1)
  );

  // A simultaneous read+write request is treated as a write.
  mem_port_fsm #(
    .DATA_W  (WORD_SIZE),
    .IDX_W   (IDX_W),
    .LATENCY (LATENCY)
  ) u_port2 (
    .Clk       (Clk),
    .Reset_N   (Reset_N),
    .req       (readM2 | writeM2),
    .wr_req    (writeM2),
    .idx       (address2[IDX_W-1:0]),
    .wdata     (data2),
    .rdata     (rdata2),
    .ready     (ready2),
    .rd_done   (rd_done2),
    .wr_commit (wr_commit2),
    .idx_q     (idx2_q),
    .data_q    (data_q2)
  );

  assign data2 = rd_done2 ? data_q2 : {WORD_SIZE{1'bz}};

  // No reset on the array: contents survive Reset_N.
  always_ff @(posedge Clk) begin
    if (wr_commit2) begin
      mem[idx2_q] <= data_q2;
    end
  end

  assign unused_bits = ^{address1[WORD_SIZE-1:IDX_W], address2[WORD_SIZE-1:IDX_W],
                         rd_done1, wr_commit1};

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed vector bench for mem_responder
module tb_mem_responder;

  typedef struct {
    logic [1:0]  kind;   // 0 p1 read, 1 p2 read, 2 p2 write, 3 p2 read+write
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  logic        Clk;
  logic        Reset_N;
  logic        readM1;
  logic [15:0] address1;
  logic [15:0] data1;
  logic        ready1;
  logic        readM2;
  logic        writeM2;
  logic [15:0] address2;
  tri1  [15:0] data2;
  logic        ready2;

  logic        d2_oe;
  logic [15:0] d2_val;

  int n_cmp;
  int n_bad;

  vec_t vecs[9];

  assign data2 = d2_oe ? d2_val : 16'hzzzz;

  mem_responder #(
    .WORD_SIZE (16),
    .DEPTH     (256),
    .LATENCY   (2)
  ) dut (
    .Clk      (Clk),
    .Reset_N  (Reset_N),
    .readM1   (readM1),
    .address1 (address1),
    .data1    (data1),
    .ready1   (ready1),
    .readM2   (readM2),
    .writeM2  (writeM2),
    .address2 (address2),
    .data2    (data2),
    .ready2   (ready2)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    readM1  = 1'b0;
    readM2  = 1'b0;
    writeM2 = 1'b0;
    d2_oe   = 1'b0;
  endtask

  // Starts at a negedge; the request is accepted on the next edge (edge 0).
  task automatic run_vec(input int i, input vec_t v);
    logic [3:0]  rs;
    logic [15:0] dat;
    logic [15:0] bus_after;
    logic [15:0] d1_after;
    address1 = v.addr;
    address2 = v.addr;
    readM1   = (v.kind == 2'd0);
    readM2   = (v.kind == 2'd1) || (v.kind == 2'd3);
    writeM2  = (v.kind >= 2'd2);
    d2_oe    = (v.kind >= 2'd2);
    d2_val   = v.wdata;
    rs = '0;
    dat = '0;
    bus_after = '0;
    d1_after = '0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      rs[k] = (v.kind == 2'd0) ? ready1 : ready2;
      if (k == 2) dat = (v.kind == 2'd0) ? data1 : data2;
      if (k == 3) begin
        bus_after = data2;
        d1_after  = data1;
      end
      if (k == 0) begin
        readM1 = 1'b0; readM2 = 1'b0; writeM2 = 1'b0;
        address1 = ~v.addr; address2 = ~v.addr;
        d2_oe = 1'b1; d2_val = 16'h0BAD;
      end
      if (k == 1) d2_oe = 1'b0;
    end
    check($sformatf("vec%0d_ready_seq", i), 32'(rs), 32'h4);
    check($sformatf("vec%0d_data_done", i), 32'(dat),
          (v.kind >= 2'd2) ? 32'hFFFF : 32'(v.exp));
    check($sformatf("vec%0d_data2_after", i), 32'(bus_after), 32'hFFFF);
    if (v.kind == 2'd0)
      check($sformatf("vec%0d_data1_hold", i), 32'(d1_after), 32'(v.exp));
    if (v.kind >= 2'd2)
      check($sformatf("vec%0d_mem_written", i), 32'(dut.mem[v.addr[7:0]]), 32'(v.wdata));
  endtask

  initial begin
    logic [13:0] mask;
    logic        r2_seen;
    n_cmp = 0;
    n_bad = 0;
    Reset_N  = 1'b0;
    address1 = '0;
    address2 = '0;
    d2_val   = '0;
    idle_inputs();

    vecs[0] = '{2'd0, 16'h0010, 16'h0000, 16'h1234};
    vecs[1] = '{2'd0, 16'hAB11, 16'h0000, 16'hCAFE};
    vecs[2] = '{2'd2, 16'h0020, 16'hBEEF, 16'h0000};
    vecs[3] = '{2'd1, 16'h0020, 16'h0000, 16'hBEEF};
    vecs[4] = '{2'd0, 16'h0020, 16'h0000, 16'hBEEF};
    vecs[5] = '{2'd3, 16'h0050, 16'h7777, 16'h0000};
    vecs[6] = '{2'd1, 16'h0050, 16'h0000, 16'h7777};
    vecs[7] = '{2'd1, 16'h107F, 16'h0000, 16'h0F0F};
    vecs[8] = '{2'd0, 16'h0000, 16'h0000, 16'h0000};

    for (int a = 0; a < 256; a++) dut.mem[a] = 16'h0000;
    dut.mem[8'h10] = 16'h1234;
    dut.mem[8'h11] = 16'hCAFE;
    dut.mem[8'h30] = 16'h0001;
    dut.mem[8'h7F] = 16'h0F0F;

    #1;
    check("reset_ready1", 32'(ready1), 32'h0);
    check("reset_ready2", 32'(ready2), 32'h0);
    check("reset_data1", 32'(data1), 32'h0);
    check("reset_data2_z", 32'(data2), 32'hFFFF);
    @(negedge Clk);
    @(negedge Clk);
    Reset_N = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Same-edge port-1 read and port-2 write of one index.
    readM1 = 1'b1; address1 = 16'h0030;
    writeM2 = 1'b1; address2 = 16'h0030;
    d2_oe = 1'b1; d2_val = 16'hAAAA;
    cyc();
    idle_inputs();
    cyc();
    cyc();
    check("conflict_readies", 32'({ready1, ready2}), 32'h3);
    check("conflict_data1_old", 32'(data1), 32'h0001);
    cyc();
    check("conflict_mem_new", 32'(dut.mem[8'h30]), 32'hAAAA);

    // Held request: accepts at edges 0,3,6,9.
    readM1 = 1'b1; address1 = 16'h0011;
    mask = '0;
    for (int k = 0; k < 14; k++) begin
      cyc();
      mask[k] = ready1;
      if (k == 9) readM1 = 1'b0;
    end
    check("held_ready_mask", 32'(mask), 32'h0924);
    check("held_data1", 32'(data1), 32'hCAFE);

    // Reset while port 1 is in DONE and port 2 write is in BUSY.
    readM1 = 1'b1; address1 = 16'h0010;
    cyc();
    readM1 = 1'b0;
    writeM2 = 1'b1; address2 = 16'h0040;
    d2_oe = 1'b1; d2_val = 16'h5555;
    cyc();
    idle_inputs();
    r2_seen = ready2;
    cyc();
    r2_seen = r2_seen | ready2;
    check("rst_pre_ready1", 32'(ready1), 32'h1);
    #1 Reset_N = 1'b0;
    #1;
    check("rst_async_ready1", 32'(ready1), 32'h0);
    check("rst_async_ready2", 32'(ready2), 32'h0);
    check("rst_async_data1", 32'(data1), 32'h0);
    check("rst_async_data2_z", 32'(data2), 32'hFFFF);
    cyc();
    r2_seen = r2_seen | ready2;
    cyc();
    r2_seen = r2_seen | ready2;
    Reset_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      r2_seen = r2_seen | ready2;
    end
    check("rst_no_ready2", 32'(r2_seen), 32'h0);
    check("rst_no_write", 32'(dut.mem[8'h40]), 32'h0000);
    check("rst_mem_kept", 32'(dut.mem[8'h10]), 32'h1234);

    run_vec(9, vecs[0]);
    run_vec(10, vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
